uart_matrix_result_tx: RTL and testbench

- Transmit side of the matrix-multiplier UART link: returns the full 3x3 result to the host, not just one byte.
- On a result_valid pulse it latches the packed 72-bit result matrix.
- It then serialises the matrix as 9 consecutive UART 8N1 bytes, C00 (result[71:64]) first through C22 (result[7:0]) last.
- Byte order matches the order the receive path loads matrix_a/matrix_b, so one host frame format applies both directions.

---
 rtl/uart_matrix_result_tx.sv | 93 +++++++++
 tb/tb_uart_matrix_result_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_result_tx.sv
// uart_matrix_result_tx: latches a packed NUM_BYTES-byte result and sends it as back-to-back UART 8N1 bytes,
// most significant byte first, matching the receive path's load order.
module uart_matrix_result_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int NUM_BYTES    = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_BYTES*8-1:0] result_in,
   input  logic                   result_valid,
   output logic                   tx,
   output logic                   busy,
   output logic                   byte_sent,
   output logic                   frame_done,
   output logic                   dropped
);
   localparam int W = NUM_BYTES * 8;
   localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
   localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [W-1:0]  frame_reg;
   logic [W-1:0]  frame_next;
   logic [7:0]    shift_reg;
   logic [15:0]   clk_count;
   logic [2:0]    bit_idx;
   logic [BW-1:0] byte_idx;
   logic          bit_end;

   assign bit_end    = clk_count == LAST_CLK;
   assign frame_next = frame_reg << 8;

   // tx is set on the edge that enters each bit, so every bit is held exactly CLKS_PER_BIT cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         frame_reg  <= '0;
         shift_reg  <= '0;
         clk_count  <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         byte_sent  <= 1'b0;
         frame_done <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         byte_sent  <= 1'b0;
         frame_done <= 1'b0;
         dropped    <= result_valid && state != IDLE;
         clk_count  <= (state == IDLE || bit_end) ? '0 : clk_count + 16'd1;
         case (state)
            IDLE: if (result_valid) begin
               state     <= START;
               frame_reg <= result_in;
               shift_reg <= result_in[W-1 -: 8];
               byte_idx  <= '0;
               bit_idx   <= '0;
               tx        <= 1'b0;
               busy      <= 1'b1;
            end
            START: if (bit_end) begin
               state <= DATA;
               tx    <= shift_reg[0];
            end
            DATA: if (bit_end) begin
               shift_reg <= shift_reg >> 1;
               bit_idx   <= bit_idx + 3'd1;
               state     <= bit_idx == 3'd7 ? STOP : DATA;
               tx        <= bit_idx == 3'd7 ? 1'b1 : shift_reg[1];
            end
            STOP: if (bit_end) begin
               byte_sent <= 1'b1;
               if (byte_idx != LAST_BYTE) begin
                  state     <= START;
                  tx        <= 1'b0;
                  byte_idx  <= byte_idx + BW'(1);
                  frame_reg <= frame_next;
                  shift_reg <= frame_next[W-1 -: 8];
               end else begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_matrix_result_tx.sv
// tb_uart_matrix_result_tx: randomized bench; an acceptance/timing model fills queues that a UART decoder
// and pulse monitors drain and compare against the DUT.
module tb_uart_matrix_result_tx;
   localparam int CPB   = 4;
   localparam int N     = 9;
   localparam int W     = N * 8;
   localparam int BYTE  = 10 * CPB;
   localparam int FRAME = N * BYTE;
   localparam int CPB87 = 87;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [W-1:0] data = '0;
   logic [W-1:0] data87 = '0;
   logic valid = 1'b0;
   logic valid87 = 1'b0;
   logic tx, busy, byte_sent, frame_done, dropped;
   logic tx87, busy87, bs87, fd87, dr87;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int free_at = 0;
   int drop_exp = 0;
   int drop_seen = 0;
   int epoch = 0;
   int dr87_seen = 0;
   int bs87_seen = 0;
   logic [7:0] exp_q[$];
   int done_q[$];
   int bs_q[$];

   always #5 clk = ~clk;

   uart_matrix_result_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(N)) dut (
      .clk(clk), .rst_n(rst_n), .result_in(data), .result_valid(valid),
      .tx(tx), .busy(busy), .byte_sent(byte_sent), .frame_done(frame_done), .dropped(dropped)
   );

   uart_matrix_result_tx #(.CLKS_PER_BIT(CPB87), .NUM_BYTES(N)) dut87 (
      .clk(clk), .rst_n(rst_n), .result_in(data87), .result_valid(valid87),
      .tx(tx87), .busy(busy87), .byte_sent(bs87), .frame_done(fd87), .dropped(dr87)
   );

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (!frame_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("frame_done_seen", int'(frame_done), 1);
      @(negedge clk);
   endtask

   // Reference model: an accepted request yields N bytes, a byte_sent every BYTE cycles and frame_done
   // FRAME cycles after acceptance; the line is free again one cycle after frame_done.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         done_q.delete();
         bs_q.delete();
         free_at = 0;
      end else if (valid) begin
         if (cyc >= free_at) begin
            for (int k = 0; k < N; k++) begin
               exp_q.push_back(data[W-1-8*k -: 8]);
               bs_q.push_back(cyc + (k + 1) * BYTE);
            end
            done_q.push_back(cyc + FRAME);
            free_at = cyc + FRAME + 1;
         end else drop_exp++;
      end
   end

   initial forever begin
      @(negedge rst_n);
      epoch++;
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (frame_done) begin
            chk("frame_done_time", cyc, done_q.size() > 0 ? done_q[0] : -1);
            chk("busy_low_at_done", int'(busy), 0);
            if (done_q.size() > 0) void'(done_q.pop_front());
         end
         if (byte_sent) begin
            chk("byte_sent_time", cyc, bs_q.size() > 0 ? bs_q[0] : -1);
            if (bs_q.size() > 0) void'(bs_q.pop_front());
         end
         if (dropped) drop_seen++;
      end
      if (dr87) dr87_seen++;
      if (bs87) bs87_seen++;
   end

   // UART receiver: samples each bit mid-way; bytes cut short by a reset are discarded
   initial forever begin
      @(negedge clk);
      if (rst_n && !tx) begin : rx
         int ep;
         logic [7:0] b;
         logic framing;
         ep = epoch;
         repeat (CPB / 2) @(negedge clk);
         framing = !tx;
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         framing = framing && tx;
         if (ep == epoch) begin
            chk("rx_framing", int'(framing), 1);
            chk("rx_byte", int'(b), exp_q.size() > 0 ? int'(exp_q[0]) : -1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         repeat (CPB - CPB / 2 - 1) @(negedge clk);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int e, t, n, bad, lows, first_low;
      logic [95:0] r;
      repeat (3) @(negedge clk);
      chk("reset_tx", int'(tx), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_byte_sent", int'(byte_sent), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_dropped", int'(dropped), 0);
      chk("reset_tx87", int'(tx87), 1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // single frame with input change after acceptance and two overrun pulses
      data  = 72'h1E242A425160667E96;
      valid = 1'b1;
      e     = cyc + 1;
      @(negedge clk);
      valid = 1'b0;
      data  = '1;
      chk("tx_start_latency", int'(tx), 0);
      bad = 0;
      for (int i = 0; i < FRAME - 1; i++) begin
         valid = i == 3 * BYTE + 14;
         if (!busy) bad++;
         @(negedge clk);
      end
      if (!busy) bad++;
      chk("busy_hold", bad, 0);
      valid = 1'b1;
      @(negedge clk);
      chk("done_cycle_frame_done", int'(frame_done), 1);
      chk("done_cycle_tx_idle", int'(tx), 1);
      chk("dropped_last_stop", int'(dropped), 1);
      data = 72'h010203040506070809;
      @(negedge clk);
      valid = 1'b0;
      chk("b2b_start", int'(tx), 0);
      chk("b2b_busy", int'(busy), 1);
      wait_done(FRAME + 5);

      repeat (8) begin
         repeat ($urandom_range(1, 450)) @(negedge clk);
         r     = {$urandom, $urandom, $urandom};
         data  = r[W-1:0];
         valid = 1'b1;
         @(negedge clk);
         valid = 1'b0;
      end
      repeat (FRAME + 20) @(negedge clk);

      // reset during byte 4 bit 2 (0x51, bit 2 is 0)
      data  = 72'h1E242A425160667E96;
      valid = 1'b1;
      e     = cyc + 1;
      @(negedge clk);
      valid = 1'b0;
      while (cyc < e + 4 * BYTE + 13) @(negedge clk);
      chk("pre_reset_tx_low", int'(tx), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_tx", int'(tx), 1);
      chk("async_reset_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (!tx || busy) lows++;
      end
      chk("post_reset_idle", lows, 0);
      r     = {$urandom, $urandom, $urandom};
      data  = r[W-1:0];
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      wait_done(FRAME + 5);

      // default bit time, valid held for five cycles
      r      = {$urandom, $urandom, $urandom};
      data87 = r[W-1:0];
      data87[W-8] = 1'b1;
      valid87   = 1'b1;
      e         = cyc + 1;
      first_low = -1;
      lows      = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (i == 4) valid87 = 1'b0;
         if (!tx87) begin
            lows++;
            if (first_low < 0) first_low = cyc;
         end
      end
      chk("cpb87_start_latency", first_low, e);
      chk("cpb87_start_width", lows, CPB87);
      n = 0;
      while (!fd87 && n < 8000) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      chk("cpb87_frame_len", t - e, N * 10 * CPB87);
      chk("cpb87_busy_done", int'(busy87), 0);
      repeat (5) @(negedge clk);
      chk("cpb87_dropped", dr87_seen, 4);
      chk("cpb87_byte_sent", bs87_seen, N);

      chk("drop_count", drop_seen, drop_exp);
      chk("bytes_outstanding", exp_q.size(), 0);
      chk("done_outstanding", done_q.size(), 0);
      chk("byte_sent_outstanding", bs_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
